// File: rtl/i2c_target_regfile.sv
//-----------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target with a small byte register file. Scl/Sda are oversampled on Clk;
// START/STOP are detected in every state, a 7-bit device address is matched,
// and write (pointer + data burst) and read (burst from pointer) transactions
// are serviced. The register file is also visible to local logic through a
// combinational read port and per-byte write strobes.
//
// Optional build macro: I2C_GLITCH_FILTER_EN
//   defined   : 3-sample majority filter after the synchronizers (suppresses
//               1-Clk pulses, adds 2 Clk of detection latency)
//   undefined : synchronizer outputs used directly
//
// Ports
//   Clk         system clock, >= 8x Scl frequency
//   Reset       asynchronous active-low reset
//   Scl         bus clock
//   Sda_in      bus data as seen on the wire
//   Sda_oe      1 = pull Sda low, 0 = release
//   Host_addr   local read-port address
//   Host_rdata  register[Host_addr], combinational
//   Wr_strobe   one-Clk pulse per byte written over I2C
//   Wr_addr     register written, valid with Wr_strobe
//   Wr_data     byte written, valid with Wr_strobe
//   Busy        high from an address-matched START until STOP
//-----------------------------------------------------------------------------
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | bus idle, waiting for START
// S_ADDR     | shifting device address + R/W
// S_ACK_A    | acknowledging address byte
// S_PTR      | shifting register pointer byte
// S_ACK_P    | acknowledging pointer byte
// S_WR_BYTE  | shifting a data byte to be written
// S_ACK_W    | acknowledging a written data byte
// S_RD_BYTE  | driving a register byte onto Sda
// S_RD_ACK   | sampling master ACK/NACK after a read byte
// S_IGNORE   | not addressed or read ended; wait for START/STOP
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'b1110000,
  parameter int         REG_AW   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Scl,
  input  logic              Sda_in,
  output logic              Sda_oe,
  input  logic [REG_AW-1:0] Host_addr,
  output logic [7:0]        Host_rdata,
  output logic              Wr_strobe,
  output logic [REG_AW-1:0] Wr_addr,
  output logic [7:0]        Wr_data,
  output logic              Busy
);

  localparam int                NREG    = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P,
    S_WR_BYTE, S_ACK_W, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_e;

  // Input conditioning. Synchronizers reset to 1 (idle bus) so leaving
  // reset does not fabricate edges.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], Scl};
      sda_sync_q <= {sda_sync_q[0], Sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
    end
  end

  assign scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                 (scl_hist_q[1] & scl_hist_q[2]);
  assign sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                 (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  // Scl must be high on both samples so an Sda edge coinciding with an Scl
  // edge is not taken as a bus condition.
  assign start_c  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_c   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic [REG_AW-1:0] ptr_q;
  logic              rw_q;
  logic              bit9_q;     // ninth (ACK) bit phase reached
  logic              wr_pend_q;  // commit received byte on the next Clk
  logic [7:0]        regs_q [NREG];

  assign shift_d    = {shift_q[6:0], sda_f};
  assign Host_rdata = regs_q[Host_addr];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      bit9_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      Sda_oe    <= 1'b0;
      Wr_strobe <= 1'b0;
      Wr_addr   <= '0;
      Wr_data   <= 8'h00;
      Busy      <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      Wr_strobe <= 1'b0;
      if (start_c) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 3'd0;
        bit9_q    <= 1'b0;
        Sda_oe    <= 1'b0;
      end else if (stop_c) begin
        state_q <= S_IDLE;
        Busy    <= 1'b0;
        Sda_oe  <= 1'b0;
      end else begin
        unique case (state_q)
          S_ADDR, S_PTR, S_WR_BYTE: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              bit9_q    <= 1'b0;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == S_ADDR) begin
                  if (shift_d[7:1] == DEV_ADDR) begin
                    state_q <= S_ACK_A;
                    Busy    <= 1'b1;
                    rw_q    <= shift_d[0];
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_PTR) begin
                  ptr_q   <= shift_d[REG_AW-1:0];
                  state_q <= S_ACK_P;
                end else begin
                  wr_pend_q <= 1'b1;
                  state_q   <= S_ACK_W;
                end
              end
            end
          end
          S_ACK_A, S_ACK_P, S_ACK_W: begin
            if (scl_rise) begin
              bit9_q <= 1'b1;
            end else if (scl_fall) begin
              if (!bit9_q) begin
                Sda_oe <= 1'b1;
              end else begin
                bit9_q    <= 1'b0;
                bit_cnt_q <= 3'd0;
                if (state_q == S_ACK_A && rw_q) begin
                  // The falling edge that ends the ACK also presents bit 7.
                  shift_q <= regs_q[ptr_q];
                  Sda_oe  <= ~regs_q[ptr_q][7];
                  state_q <= S_RD_BYTE;
                end else begin
                  Sda_oe  <= 1'b0;
                  state_q <= (state_q == S_ACK_A) ? S_PTR : S_WR_BYTE;
                end
              end
            end
          end
          S_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) bit9_q <= 1'b1;
            end else if (scl_fall) begin
              if (bit9_q) begin
                Sda_oe  <= 1'b0;
                bit9_q  <= 1'b0;
                state_q <= S_RD_ACK;
              end else begin
                Sda_oe  <= ~shift_q[6];
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                ptr_q  <= ptr_q + PTR_ONE;
                bit9_q <= 1'b1;
              end else begin
                state_q <= S_IGNORE;
              end
            end else if (scl_fall && bit9_q) begin
              shift_q   <= regs_q[ptr_q];
              Sda_oe    <= ~regs_q[ptr_q][7];
              bit9_q    <= 1'b0;
              bit_cnt_q <= 3'd0;
              state_q   <= S_RD_BYTE;
            end
          end
          default: begin
            Sda_oe <= 1'b0;
          end
        endcase
      end

      if (wr_pend_q) begin
        regs_q[ptr_q] <= shift_q;
        Wr_strobe     <= 1'b1;
        Wr_addr       <= ptr_q;
        Wr_data       <= shift_q;
        ptr_q         <= ptr_q + PTR_ONE;
        wr_pend_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 8;  // Clk periods per quarter Scl period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] host_addr = 4'h0;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] host_rdata, wr_data;
  logic [3:0] wr_addr;
  wire        sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(.DEV_ADDR(7'b1110000), .REG_AW(4)) dut (
    .Clk(clk), .Reset(rst_n), .Scl(scl), .Sda_in(sda_bus), .Sda_oe(sda_oe),
    .Host_addr(host_addr), .Host_rdata(host_rdata), .Wr_strobe(wr_strobe),
    .Wr_addr(wr_addr), .Wr_data(wr_data), .Busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] got_rd_q[$];
  int oe_cnt = 0, busy_cnt = 0, strobe_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pops expected write strobes and read bytes as the DUT produces them.
  always @(negedge clk) begin : mon
    wr_t        e;
    logic [7:0] g, x;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (wr_strobe) begin
      strobe_cnt++;
      if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h", wr_addr, wr_data);
      end else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
    if (got_rd_q.size() > 0) begin
      g = got_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got 0x%0h", g);
      end else begin
        x = exp_rd_q.pop_front();
        chk("rd_byte", {24'd0, g}, {24'd0, x});
      end
    end
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait(); scl = 1'b1; qwait(); m_sda = 1'b0; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait(); scl = 1'b1; qwait(); m_sda = 1'b1; qwait(); qwait();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; qwait(); scl = 1'b1; qwait(); qwait(); scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_sda = 1'b1; qwait(); scl = 1'b1; qwait(); ack = sda_bus; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qwait(); scl = 1'b1; qwait(); b[i] = sda_bus; qwait(); scl = 1'b0; qwait();
    end
    m_sda = ~m_ack; qwait(); scl = 1'b1; qwait(); qwait(); scl = 1'b0; qwait();
    got_rd_q.push_back(b);
  endtask

  task automatic chk_reg(input logic [3:0] a, input logic [7:0] v, input string nm);
    @(negedge clk); host_addr = a; #1;
    chk(nm, {24'd0, host_rdata}, {24'd0, v});
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic       ack;
    logic [7:0] rb;
    int o0, b0, s0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_strobe", {31'd0, wr_strobe}, 0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk_reg(4'h3, 8'h00, "rst_reg3");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write burst: E0, 03, A5, 5A
    exp_wr_q.push_back({4'h3, 8'hA5});
    exp_wr_q.push_back({4'h4, 8'h5A});
    i2c_start();
    write_byte(8'hE0, ack); chk("wb_ack_addr", {31'd0, ack}, 0);
    chk("wb_busy_hi", {31'd0, busy}, 1);
    write_byte(8'h03, ack); chk("wb_ack_ptr", {31'd0, ack}, 0);
    write_byte(8'hA5, ack); chk("wb_ack_d0", {31'd0, ack}, 0);
    write_byte(8'h5A, ack); chk("wb_ack_d1", {31'd0, ack}, 0);
    chk("wb_busy_before_stop", {31'd0, busy}, 1);
    i2c_stop();
    chk("wb_busy_after_stop", {31'd0, busy}, 0);
    chk_reg(4'h3, 8'hA5, "wb_reg3");
    chk_reg(4'h4, 8'h5A, "wb_reg4");
    chk_reg(4'h5, 8'h00, "wb_reg5_untouched");

    // Read with repeated START
    exp_rd_q.push_back(8'hA5);
    exp_rd_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'hE0, ack); chk("rd_ack_addr_w", {31'd0, ack}, 0);
    write_byte(8'h03, ack); chk("rd_ack_ptr", {31'd0, ack}, 0);
    i2c_start();
    write_byte(8'hE1, ack); chk("rd_ack_addr_r", {31'd0, ack}, 0);
    read_byte(1'b1, rb);
    read_byte(1'b0, rb);
    chk("rd_released_after_nack", {31'd0, sda_oe}, 0);
    i2c_stop();
    chk("rd_busy_after_stop", {31'd0, busy}, 0);

    // Address mismatch
    o0 = oe_cnt; b0 = busy_cnt; s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h42, ack); chk("mm_nack_addr", {31'd0, ack}, 1);
    write_byte(8'h00, ack); chk("mm_nack_data", {31'd0, ack}, 1);
    i2c_stop();
    chk("mm_no_oe", oe_cnt, o0);
    chk("mm_no_busy", busy_cnt, b0);
    chk("mm_no_strobe", strobe_cnt, s0);

    // Pointer wrap
    exp_wr_q.push_back({4'hF, 8'h11});
    exp_wr_q.push_back({4'h0, 8'h22});
    i2c_start();
    write_byte(8'hE0, ack); chk("wr_ack_addr", {31'd0, ack}, 0);
    write_byte(8'h0F, ack); chk("wr_ack_ptr", {31'd0, ack}, 0);
    write_byte(8'h11, ack); chk("wr_ack_d0", {31'd0, ack}, 0);
    write_byte(8'h22, ack); chk("wr_ack_d1", {31'd0, ack}, 0);
    i2c_stop();
    chk_reg(4'hF, 8'h11, "wrap_reg15");
    chk_reg(4'h0, 8'h22, "wrap_reg0");

    // Reset mid-byte after four data bits
    i2c_start();
    write_byte(8'hE0, ack);
    write_byte(8'h07, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sda_oe", {31'd0, sda_oe}, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk_reg(4'h3, 8'h00, "mr_reg3");
    chk_reg(4'h4, 8'h00, "mr_reg4");
    chk_reg(4'hF, 8'h00, "mr_reg15");
    chk_reg(4'h0, 8'h00, "mr_reg0");
    scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    qwait();
    exp_wr_q.push_back({4'h5, 8'hC3});
    i2c_start();
    write_byte(8'hE0, ack); chk("pr_ack_addr", {31'd0, ack}, 0);
    write_byte(8'h05, ack); chk("pr_ack_ptr", {31'd0, ack}, 0);
    write_byte(8'hC3, ack); chk("pr_ack_data", {31'd0, ack}, 0);
    i2c_stop();
    chk_reg(4'h5, 8'hC3, "pr_reg5");

`ifdef I2C_GLITCH_FILTER_EN
    // 1-Clk Sda low pulse with Scl high must not be taken as START
    o0 = oe_cnt;
    @(negedge clk); m_sda = 1'b0;
    @(negedge clk); m_sda = 1'b1;
    qwait();
    chk("gl_busy", {31'd0, busy}, 0);
    write_byte(8'hE0, ack); chk("gl_no_ack", {31'd0, ack}, 1);
    i2c_stop();
    chk("gl_no_oe", oe_cnt, o0);
`endif

    repeat (20) @(negedge clk);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
